// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
//   Bit-serial unsigned adder. It computes {cout,sum} = a + b + cin one bit
//   per clock, LSB first, through a single 1-bit full adder (fadd). The
//   carry-out of each bit is registered and becomes the carry-in of the next.
//   A result takes WIDTH clocks, in exchange for a very small datapath.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 1)
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request; sampled only while idle
//   a, b   in   operands (WIDTH bits); captured on an accepted start
//   cin    in   initial carry; captured on an accepted start
//   busy   out  high while an addition is in progress
//   done   out  one-cycle pulse; sum/cout valid
//   sum    out  result (WIDTH bits); valid from done until the next accept
//   cout   out  final carry; same validity as sum
//   ovf    out  (only with SERIAL_ADDER_OVF_EN) signed two's-complement
//               overflow of a+b+cin; same validity as cout
//
// Configuration macro
//   SERIAL_ADDER_OVF_EN  when defined, adds the ovf output and its register.
// ----------------------------------------------------------------------------

// 1-bit full adder
module fadd (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Counter needs at least one bit even when WIDTH is 1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_shift;

  fadd u_fadd (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB so the result ends up LSB-aligned after
  // WIDTH shifts. A 1-bit result is simply the current sum bit.
  generate
    if (WIDTH == 1) begin : g_shift_w1
      assign sum_shift = fa_sum;
    end else begin : g_shift_wn
      assign sum_shift = {fa_sum, sum[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      // done is a pulse: it only survives an edge that completes an add.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum   <= sum_shift;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout  <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
            // carry still holds the carry into the MSB at this point.
            ovf   <= carry ^ fa_cout;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder that computes an N-bit sum one bit per clock through a single instance of the team's 1-bit full adder `fadd` (ports a, b, cin, sum, cout).
- Feeds `fadd` LSB-first from operand shift registers and consumes its sum/cout each cycle.
- The carry-out is registered as the next cycle's carry-in.
- Used where area matters more than latency.
- Start/done handshake toward a controlling FSM.

Parameters:
- WIDTH, 32, operand and result width in bits (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  initial carry; captured on accepted start.
- busy  output  1  high while an addition is in progress.
- done  output  1  single-cycle pulse; result valid.
- sum  output  WIDTH  result; valid from done until the next accepted start.
- cout  output  1  final carry; same validity as sum.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry and bit counter cleared.
- States:
  - IDLE → RUN on start=1.
  - RUN → IDLE after WIDTH bit-cycles.
  - No other states.
- Accept (edge E0, state IDLE, start=1):
  - A_sh<=a, B_sh<=b, carry<=cin, cnt<=0.
  - busy<=1, done<=0, state<=RUN.
- RUN, each edge:
  - `fadd` inputs are A_sh[0], B_sh[0], carry.
  - Result register shifts right, taking the fadd sum bit into bit WIDTH-1.
  - A_sh and B_sh shift right, filling with 0.
  - carry<=fadd cout; cnt<=cnt+1.
- Completion (edge E_WIDTH, cnt==WIDTH-1):
  - Last bit shifted in, so sum holds the full LSB-aligned result.
  - cout<=final fadd cout.
  - busy<=0, done<=1, state<=IDLE.
- done timing:
  - done is high for exactly the cycle following E_WIDTH.
  - It clears on the next edge unless a new completion occurs.
- Latency: WIDTH clocks from the start-sampling edge to done asserted.
  - Throughput: one operation per WIDTH+1 cycles when start is held high.
- Arithmetic: {cout,sum} = a + b + cin modulo 2^(WIDTH+1). Unsigned; no saturation.
- cnt width: $clog2(WIDTH), minimum 1 bit.
- Boundary conditions:
  - start while busy=1: ignored, no effect on the operation in flight, not queued.
  - start in the done cycle: accepted (state is IDLE). done still pulses that cycle, and busy goes high on the same edge done falls.
  - sum/cout while busy: hold partial/stale values; consumers must not sample them.
  - sum/cout after done: hold until the next accepted start. They are not cleared on accept; they shift during RUN.
  - WIDTH=1: single RUN cycle; done pulse one cycle after accept.
  - Reset mid-operation: operation abandoned immediately; all outputs return to reset values; no done pulse is produced.
  - Inputs a, b, cin may change freely after the accept edge.

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), signed two's-complement overflow of a+b+cin.
  - Computed at the completion edge as the carry into bit WIDTH-1 XOR final cout. The carry into bit WIDTH-1 is the registered carry before the last bit.
  - Same reset value (0) and validity window as cout.
- Undefined:
  - Port absent; no extra logic.
  - All other behaviour identical.

Test Plan:
- WIDTH=8, a=0x03, b=0x05, cin=0, start one cycle → busy high 8 cycles, done pulse 8 clocks after accept, sum=0x08, cout=0.
- WIDTH=8, a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0x00, b=0x00, cin=1 → sum=0x01, cout=0.
- WIDTH=8, accept a=0x10, b=0x20. Pulse start with a=0xFF, b=0xFF at cycles 2 and 5 → ignored; sum=0x30, cout=0; exactly one done pulse.
- WIDTH=32, start held high, operands 0xFFFFFFFF+0x00000001 then 0x12345678+0x11111111 → back-to-back done pulses 33 cycles apart. Results 0x00000000/cout=1, then 0x23456789/cout=0.
- WIDTH=8, accept 0xAA+0x55, assert rst_n=0 at cycle 4 → busy, done, sum, cout go 0 asynchronously. No done after release; a fresh 0x01+0x01 then yields 0x02.
- SERIAL_ADDER_OVF_EN defined, WIDTH=8:
  - 0x7F+0x01 → sum=0x80, cout=0, ovf=1.
  - 0x80+0x80 → sum=0x00, cout=1, ovf=1.
  - 0xFF+0x01 → ovf=0.
